// File: rtl/ram_latency_ctrl_if.sv
// Status type shared with the coherence controller, and the bundle tying the
// requester, latency controller and word SRAM together.
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

interface ram_latency_ctrl_if #(
    parameter int AW = 14
);
    logic                     ramREN;
    logic                     ramWEN;
    logic [31:0]              ramaddr;
    logic [31:0]              ramstore;
    logic [31:0]              ramload;
    cpu_types_pkg::ramstate_t ramstate;

    logic [AW-1:0]            mem_addr;
    logic [31:0]              mem_wdata;
    logic                     mem_we;
    logic                     mem_re;
    logic [31:0]              mem_rdata;

    logic [15:0]              stat_rd;
    logic [15:0]              stat_wr;
    logic [15:0]              stat_err;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate, stat_rd, stat_wr, stat_err
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore, mem_rdata,
        output ramload, ramstate, mem_addr, mem_wdata, mem_we, mem_re,
        output stat_rd, stat_wr, stat_err
    );

    modport sram (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/ram_latency_ctrl.sv
// Fixed-latency front end for a 1-cycle synchronous word SRAM, with illegal-request flagging.
// Optional request/error counters are built when RAM_STATS_EN is defined.
//
// state | meaning
// IDLE  | no transaction; decode and latch a new request
// WAIT  | counting down the access latency, request must stay unchanged
// ACC   | single ACCESS cycle: return read data or strobe the write
// ERR   | single ERROR cycle after an illegal request
module ram_latency_ctrl
    import cpu_types_pkg::*;
#(
    parameter int  LAT       = 2,
    parameter int  MEM_WORDS = 16384,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic              CLK,
    input  logic              RST,
    ram_latency_ctrl_if.slave bus
);

    if (LAT < 1 || LAT > 15) begin : g_lat_check
        $error("ram_latency_ctrl: LAT must be within 1..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC, S_ERR} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        we_q, we_d;

    logic        req;
    logic        illegal;
    logic        held;
    ramstate_t   ramstate_c;
    logic [31:0] ramload_c;
    logic        mem_re_c;
    logic        mem_we_c;

    assign req     = bus.ramREN | bus.ramWEN;
    assign illegal = (bus.ramREN & bus.ramWEN) || (bus.ramaddr[1:0] != 2'b00) ||
                     ({2'b00, bus.ramaddr[31:2]} >= 32'(MEM_WORDS));
    assign held    = (bus.ramREN == ~we_q) && (bus.ramWEN == we_q) && (bus.ramaddr == addr_q);

    // Status must answer in the same cycle the request appears, so it is decoded from state and inputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = we_q;
        ramstate_c = FREE;
        ramload_c  = '0;
        mem_re_c   = 1'b0;
        mem_we_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    ramstate_c = BUSY;
                    if (illegal) begin
                        state_d = S_ERR;
                    end else begin
                        addr_d = bus.ramaddr;
                        data_d = bus.ramstore;
                        we_d   = bus.ramWEN;
                        if (LAT == 1) begin
                            mem_re_c = bus.ramREN;
                            state_d  = S_ACC;
                        end else begin
                            cnt_d   = 4'(LAT - 1);
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                ramstate_c = BUSY;
                if (!held) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    mem_re_c = ~we_q;
                    state_d  = S_ACC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACC: begin
                ramstate_c = ACCESS;
                if (we_q) begin
                    mem_we_c = 1'b1;
                end else begin
                    ramload_c = bus.mem_rdata;
                end
                state_d = S_IDLE;
            end
            S_ERR: begin
                ramstate_c = ERROR;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    // With LAT==1 the read strobe fires in IDLE, before the latch holds the address.
    assign bus.mem_addr  = (state_q == S_IDLE) ? bus.ramaddr[AW+1:2] : addr_q[AW+1:2];
    assign bus.mem_wdata = data_q;
    assign bus.mem_we    = mem_we_c & ~RST;
    assign bus.mem_re    = mem_re_c & ~RST;
    assign bus.ramload   = RST ? 32'd0 : ramload_c;
    assign bus.ramstate  = ramstate_c;

`ifdef RAM_STATS_EN
    logic [15:0] stat_rd_q;
    logic [15:0] stat_wr_q;
    logic [15:0] stat_err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_rd_q  <= '0;
            stat_wr_q  <= '0;
            stat_err_q <= '0;
        end else begin
            if (state_q == S_ACC && !we_q && stat_rd_q != 16'hFFFF) begin
                stat_rd_q <= stat_rd_q + 16'd1;
            end
            if (state_q == S_ACC && we_q && stat_wr_q != 16'hFFFF) begin
                stat_wr_q <= stat_wr_q + 16'd1;
            end
            if (state_q == S_ERR && stat_err_q != 16'hFFFF) begin
                stat_err_q <= stat_err_q + 16'd1;
            end
        end
    end

    assign bus.stat_rd  = stat_rd_q;
    assign bus.stat_wr  = stat_wr_q;
    assign bus.stat_err = stat_err_q;
`else
    assign bus.stat_rd  = 16'h0;
    assign bus.stat_wr  = 16'h0;
    assign bus.stat_err = 16'h0;
`endif

endmodule

// File: tb/tb_ram_latency_ctrl.sv
// Bench for ram_latency_ctrl: three instances (LAT 1, 2, 4) against a cycle-timeline model.
module tb_ram_latency_ctrl;
    import cpu_types_pkg::*;

    localparam int NI  = 3;
    localparam int MW  = 64;
    localparam int AWT = $clog2(MW);
`ifdef RAM_STATS_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEADBEEF : (32'h5A000000 ^ (32'(i) * 32'h00010203));
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic             ren_a [NI];
    logic             wen_a [NI];
    logic [31:0]      addr_a [NI];
    logic [31:0]      store_a [NI];
    logic [1:0]       st_a [NI];
    logic [31:0]      load_a [NI];
    logic [31:0]      wdata_a [NI];
    logic             re_a [NI];
    logic             we_a [NI];
    logic [AWT-1:0]   maddr_a [NI];
    logic [15:0]      srd_a [NI];
    logic [15:0]      swr_a [NI];
    logic [15:0]      serr_a [NI];

    for (genvar g = 0; g < NI; g++) begin : g_inst
        ram_latency_ctrl_if #(.AW(AWT)) u_if ();
        logic [31:0] mem [MW];
        logic [31:0] rdata_q = '0;

        ram_latency_ctrl #(.LAT(lat_of(g)), .MEM_WORDS(MW)) u_dut (
            .CLK (clk),
            .RST (rst),
            .bus (u_if.slave)
        );

        assign u_if.ramREN    = ren_a[g];
        assign u_if.ramWEN    = wen_a[g];
        assign u_if.ramaddr   = addr_a[g];
        assign u_if.ramstore  = store_a[g];
        assign u_if.mem_rdata = rdata_q;
        assign st_a[g]        = u_if.ramstate;
        assign load_a[g]      = u_if.ramload;
        assign wdata_a[g]     = u_if.mem_wdata;
        assign re_a[g]        = u_if.mem_re;
        assign we_a[g]        = u_if.mem_we;
        assign maddr_a[g]     = u_if.mem_addr;
        assign srd_a[g]       = u_if.stat_rd;
        assign swr_a[g]       = u_if.stat_wr;
        assign serr_a[g]      = u_if.stat_err;

        initial for (int i = 0; i < MW; i++) mem[i] = init_word(i);

        always @(posedge clk) begin
            if (u_if.mem_we) mem[u_if.mem_addr] <= u_if.mem_wdata;
            if (u_if.mem_re) rdata_q <= mem[u_if.mem_addr];
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc = -1;

    logic        nxt_rst;
    logic        nxt_ren [NI];
    logic        nxt_wen [NI];
    logic [31:0] nxt_addr [NI];
    logic [31:0] nxt_store [NI];

    // Model: a legal request accepted at cycle s is ACCESS at s+LAT if unchanged through s+LAT-1.
    bit          m_act [NI];
    int          m_start [NI];
    logic [31:0] m_addr [NI];
    logic [31:0] m_data [NI];
    bit          m_we [NI];
    int          m_err_at [NI];
    logic [31:0] m_mem [NI][MW];
    int          m_rd [NI];
    int          m_wr [NI];
    int          m_erc [NI];

    task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h", nm, g, cyc, got, exp);
        end
    endtask

    task automatic model_cycle(input int g);
        int          lat;
        logic        req;
        logic        bad;
        ramstate_t   es;
        logic [31:0] el;
        logic [31:0] ewd;
        logic        ere;
        logic        ewe;
        logic [AWT-1:0] ema;
        lat = lat_of(g);
        es  = FREE;
        el  = '0;
        ewd = '0;
        ere = 1'b0;
        ewe = 1'b0;
        ema = '0;
        if (rst) begin
            chk("rst_mem_re", g, 32'(re_a[g]), 32'd0);
            chk("rst_mem_we", g, 32'(we_a[g]), 32'd0);
            chk("rst_ramload", g, load_a[g], 32'd0);
            m_act[g]    = 1'b0;
            m_err_at[g] = -1;
            m_rd[g]     = 0;
            m_wr[g]     = 0;
            m_erc[g]    = 0;
            return;
        end
        chk("stat_rd", g, 32'(srd_a[g]), SE ? 32'(m_rd[g]) : 32'd0);
        chk("stat_wr", g, 32'(swr_a[g]), SE ? 32'(m_wr[g]) : 32'd0);
        chk("stat_err", g, 32'(serr_a[g]), SE ? 32'(m_erc[g]) : 32'd0);

        req = ren_a[g] | wen_a[g];
        bad = (ren_a[g] & wen_a[g]) || (addr_a[g][1:0] != 2'b00) ||
              ({2'b00, addr_a[g][31:2]} >= 32'(MW));

        if (m_act[g] && cyc < m_start[g] + lat) begin
            es = BUSY;
            if (ren_a[g] != ~m_we[g] || wen_a[g] != m_we[g] || addr_a[g] != m_addr[g]) begin
                m_act[g] = 1'b0;
            end else if (cyc == m_start[g] + lat - 1 && !m_we[g]) begin
                ere = 1'b1;
                ema = m_addr[g][AWT+1:2];
            end
        end else if (m_act[g] && cyc == m_start[g] + lat) begin
            es  = ACCESS;
            ema = m_addr[g][AWT+1:2];
            if (m_we[g]) begin
                ewe = 1'b1;
                ewd = m_data[g];
                m_mem[g][ema] = m_data[g];
                if (m_wr[g] < 65535) m_wr[g]++;
            end else begin
                el = m_mem[g][ema];
                if (m_rd[g] < 65535) m_rd[g]++;
            end
            m_act[g] = 1'b0;
        end else if (m_err_at[g] == cyc) begin
            es = ERROR;
            if (m_erc[g] < 65535) m_erc[g]++;
        end else if (req) begin
            es = BUSY;
            if (bad) begin
                m_err_at[g] = cyc + 1;
            end else begin
                m_act[g]   = 1'b1;
                m_start[g] = cyc;
                m_addr[g]  = addr_a[g];
                m_data[g]  = store_a[g];
                m_we[g]    = wen_a[g];
                if (lat == 1 && ren_a[g]) begin
                    ere = 1'b1;
                    ema = addr_a[g][AWT+1:2];
                end
            end
        end

        chk("ramstate", g, 32'(st_a[g]), 32'(es));
        chk("ramload", g, load_a[g], el);
        chk("mem_re", g, 32'(re_a[g]), 32'(ere));
        chk("mem_we", g, 32'(we_a[g]), 32'(ewe));
        if (ere || ewe) chk("mem_addr", g, 32'(maddr_a[g]), 32'(ema));
        if (ewe) chk("mem_wdata", g, wdata_a[g], ewd);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst = nxt_rst;
        for (int g = 0; g < NI; g++) begin
            ren_a[g]   = nxt_ren[g];
            wen_a[g]   = nxt_wen[g];
            addr_a[g]  = nxt_addr[g];
            store_a[g] = nxt_store[g];
        end
        #2;
        for (int g = 0; g < NI; g++) model_cycle(g);
    endtask

    task automatic drive(input int g, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        nxt_ren[g]   = r;
        nxt_wen[g]   = w;
        nxt_addr[g]  = a;
        nxt_store[g] = d;
    endtask

    task automatic set_idle();
        for (int g = 0; g < NI; g++) drive(g, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    int hold_left [NI];

    initial begin
        for (int g = 0; g < NI; g++) begin
            ren_a[g]    = 1'b0;
            wen_a[g]    = 1'b0;
            addr_a[g]   = '0;
            store_a[g]  = '0;
            m_act[g]    = 1'b0;
            m_start[g]  = 0;
            m_err_at[g] = -1;
            m_rd[g]     = 0;
            m_wr[g]     = 0;
            m_erc[g]    = 0;
            hold_left[g] = 0;
            for (int i = 0; i < MW; i++) m_mem[g][i] = init_word(i);
        end
        nxt_rst = 1'b1;
        set_idle();
        step();
        step();
        nxt_rst = 1'b0;
        step();
        chk("lit_reset_state", 1, 32'(st_a[1]), 32'(FREE));
        chk("lit_reset_stat_rd", 1, 32'(srd_a[1]), 32'd0);

        // LAT=2 read of 0x40 holding 0xDEADBEEF
        drive(1, 1'b1, 1'b0, 32'h40, 32'd0);
        step();
        chk("lit_s1_c0_state", 1, 32'(st_a[1]), 32'(BUSY));
        chk("lit_s1_c0_re", 1, 32'(re_a[1]), 32'd0);
        step();
        chk("lit_s1_c1_state", 1, 32'(st_a[1]), 32'(BUSY));
        chk("lit_s1_c1_re", 1, 32'(re_a[1]), 32'd1);
        chk("lit_s1_c1_addr", 1, 32'(maddr_a[1]), 32'h10);
        step();
        chk("lit_s1_c2_state", 1, 32'(st_a[1]), 32'(ACCESS));
        chk("lit_s1_c2_load", 1, load_a[1], 32'hDEADBEEF);
        chk("lit_s1_c2_re", 1, 32'(re_a[1]), 32'd0);
        set_idle();
        step();
        chk("lit_s1_c3_state", 1, 32'(st_a[1]), 32'(FREE));

        // LAT=1 write 0x80 then read it back
        drive(0, 1'b0, 1'b1, 32'h80, 32'h12345678);
        step();
        chk("lit_s2_c0_state", 0, 32'(st_a[0]), 32'(BUSY));
        step();
        chk("lit_s2_c1_state", 0, 32'(st_a[0]), 32'(ACCESS));
        chk("lit_s2_c1_we", 0, 32'(we_a[0]), 32'd1);
        chk("lit_s2_c1_addr", 0, 32'(maddr_a[0]), 32'h20);
        drive(0, 1'b1, 1'b0, 32'h80, 32'd0);
        step();
        chk("lit_s2_rd_re", 0, 32'(re_a[0]), 32'd1);
        step();
        chk("lit_s2_rd_load", 0, load_a[0], 32'h12345678);
        set_idle();
        step();

        // Illegal requests: both strobes, then misaligned address
        drive(1, 1'b1, 1'b1, 32'h0, 32'd0);
        step();
        chk("lit_s3_both_busy", 1, 32'(st_a[1]), 32'(BUSY));
        set_idle();
        step();
        chk("lit_s3_both_error", 1, 32'(st_a[1]), 32'(ERROR));
        chk("lit_s3_both_we", 1, 32'(we_a[1]), 32'd0);
        step();
        chk("lit_s3_stat_err1", 1, 32'(serr_a[1]), SE ? 32'd1 : 32'd0);
        drive(1, 1'b1, 1'b0, 32'h42, 32'd0);
        step();
        set_idle();
        step();
        chk("lit_s3_mis_error", 1, 32'(st_a[1]), 32'(ERROR));
        chk("lit_s3_mis_re", 1, 32'(re_a[1]), 32'd0);
        step();
        chk("lit_s3_stat_err2", 1, 32'(serr_a[1]), SE ? 32'd2 : 32'd0);

        // LAT=4 read dropped in cycle 2
        drive(2, 1'b1, 1'b0, 32'h44, 32'd0);
        step();
        step();
        set_idle();
        step();
        chk("lit_s4_c2_re", 2, 32'(re_a[2]), 32'd0);
        step();
        chk("lit_s4_c3_state", 2, 32'(st_a[2]), 32'(FREE));
        chk("lit_s4_stat_rd", 2, 32'(srd_a[2]), 32'd0);

        // Two writes; reset lands in the second write's WAIT
        drive(1, 1'b0, 1'b1, 32'h20, 32'hA5A5_0001);
        step();
        step();
        step();
        chk("lit_s5_w1_we", 1, 32'(we_a[1]), 32'd1);
        set_idle();
        step();
        drive(1, 1'b0, 1'b1, 32'h24, 32'hA5A5_0002);
        step();
        nxt_rst = 1'b1;
        step();
        chk("lit_s5_rst_we", 1, 32'(we_a[1]), 32'd0);
        nxt_rst = 1'b0;
        set_idle();
        step();
        chk("lit_s5_free", 1, 32'(st_a[1]), 32'(FREE));
        chk("lit_s5_free_we", 1, 32'(we_a[1]), 32'd0);
        chk("lit_s5_stat_err_clr", 1, 32'(serr_a[1]), 32'd0);
        drive(1, 1'b1, 1'b0, 32'h24, 32'd0);
        step();
        step();
        step();
        chk("lit_s5_rb_unwritten", 1, load_a[1], init_word(9));
        drive(1, 1'b1, 1'b0, 32'h20, 32'd0);
        step();
        step();
        step();
        chk("lit_s5_rb_written", 1, load_a[1], 32'hA5A5_0001);
        set_idle();
        step();

        for (int n = 0; n < 3000; n++) begin
            nxt_rst = ($urandom_range(0, 299) == 0);
            for (int g = 0; g < NI; g++) begin
                if (hold_left[g] == 0) begin
                    if ($urandom_range(0, 9) < 2) begin
                        drive(g, 1'b0, 1'b0, 32'd0, 32'd0);
                        hold_left[g] = $urandom_range(1, 2);
                    end else begin
                        logic [31:0] a;
                        logic        rb;
                        logic        both;
                        a = 32'($urandom_range(0, MW + 3)) << 2;
                        if ($urandom_range(0, 15) == 0) a[1:0] = 2'($urandom_range(1, 3));
                        rb   = 1'($urandom_range(0, 1));
                        both = ($urandom_range(0, 19) == 0);
                        drive(g, both | rb, both | ~rb, a, $urandom());
                        hold_left[g] = $urandom_range(1, lat_of(g) + 2);
                    end
                end
                hold_left[g]--;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
